ps2_kbmatrix: RTL and testbench

PS/2 keyboard receiver and scancode decoder. It deserialises host-side PS/2 frames from an external keyboard, interprets scancode set 2 make/break/extended sequences, and maintains the 64-bit Z88 key matrix. That matrix drives the `kbmatrix` input of the z88 top level, which Blink samples as `kbmat`. The block sits beside the Z88 core on the master clock and replaces a physical 8×8 key matrix.

---
 rtl/ps2_kbmatrix.sv | 115 +++++++++++
 tb/tb_ps2_kbmatrix.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ps2_kbmatrix.sv
// ps2_kbmatrix: PS/2 set-2 receiver and decoder driving the active-low Z88 8x8 key matrix
module ps2_kbmatrix #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [63:0] kbmatrix,
    output logic [7:0]  scan_code,
    output logic        scan_valid,
    output logic        rx_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [1:0] RX_IDLE = 2'd0, RX_BITS = 2'd1, RX_DONE = 2'd2;
    localparam logic [2:0] D_IDLE = 3'd0, D_EXT = 3'd1, D_BRK = 3'd2, D_EXTBRK = 3'd3, D_SKIP = 3'd4;
    logic [1:0]    clk_sync, dat_sync;
    logic          filt, fall, frame_ok;
    logic [7:0]    flt_cnt;
    logic [1:0]    rx_state;
    logic [3:0]    bit_cnt;
    logic [9:0]    sh;
    logic [TW-1:0] to_cnt;
    logic [2:0]    dstate, d_next, skip_cnt;
    logic          pre, ign, ext, brk, key_ev, hit;
    logic [5:0]    idx;
    function automatic logic [6:0] keymap(input logic e, input logic [7:0] code);
        case ({e, code})
            9'h01C:  keymap = {1'b1, 6'd49};
            9'h05A:  keymap = {1'b1, 6'd6};
            9'h012:  keymap = {1'b1, 6'd54};
            9'h059:  keymap = {1'b1, 6'd63};
            9'h076:  keymap = {1'b1, 6'd61};
            9'h014:  keymap = {1'b1, 6'd52};
            9'h029:  keymap = {1'b1, 6'd46};
            9'h066:  keymap = {1'b1, 6'd7};
            9'h175:  keymap = {1'b1, 6'd30};
            9'h172:  keymap = {1'b1, 6'd22};
            default: keymap = 7'd0;
        endcase
    endfunction
    assign fall     = filt & ~clk_sync[1] & (flt_cnt == 8'(FILTER_LEN - 1));
    assign frame_ok = ~sh[0] & dat_sync[1] & (^sh[9:1]);
    always_comb begin
        pre    = scan_code inside {8'hE0, 8'hF0, 8'hE1};
        ign    = scan_code inside {8'hAA, 8'hFA, 8'hEE, 8'h00, 8'hFF};
        ext    = dstate == D_EXT || dstate == D_EXTBRK;
        brk    = dstate == D_BRK || dstate == D_EXTBRK;
        key_ev = (dstate == D_IDLE && !pre && !ign) || (dstate == D_EXT && !pre) || brk;
        {hit, idx} = keymap(ext, scan_code);
        d_next = dstate == D_IDLE ? (scan_code == 8'hE0 ? D_EXT : scan_code == 8'hF0 ? D_BRK :
                                     scan_code == 8'hE1 ? D_SKIP : D_IDLE) :
                 dstate == D_EXT  ? (scan_code == 8'hF0 ? D_EXTBRK : pre ? D_EXT : D_IDLE) :
                 dstate == D_SKIP ? (skip_cnt == 3'd1 ? D_IDLE : D_SKIP) : D_IDLE;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            filt       <= 1'b1;
            flt_cnt    <= '0;
            rx_state   <= RX_IDLE;
            bit_cnt    <= '0;
            sh         <= '0;
            to_cnt     <= '0;
            scan_code  <= '0;
            scan_valid <= 1'b0;
            rx_err     <= 1'b0;
            dstate     <= D_IDLE;
            skip_cnt   <= '0;
            kbmatrix   <= '1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            dat_sync   <= {dat_sync[0], ps2_data};
            scan_valid <= 1'b0;
            rx_err     <= 1'b0;
            if (clk_sync[1] == filt)
                flt_cnt <= '0;
            else if (flt_cnt == 8'(FILTER_LEN - 1)) begin
                filt    <= clk_sync[1];
                flt_cnt <= '0;
            end else
                flt_cnt <= flt_cnt + 8'd1;
            // timeout wins over a coincident falling edge
            if (rx_state == RX_BITS && to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                rx_err   <= 1'b1;
                rx_state <= RX_IDLE;
            end else if (fall && rx_state == RX_BITS) begin
                sh      <= {dat_sync[1], sh[9:1]};
                to_cnt  <= '0;
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd10) begin
                    scan_valid <= frame_ok;
                    rx_err     <= ~frame_ok;
                    rx_state   <= RX_DONE;
                    if (frame_ok) scan_code <= sh[8:1];
                end
            end else if (fall) begin
                sh       <= {dat_sync[1], sh[9:1]};
                to_cnt   <= '0;
                bit_cnt  <= 4'd1;
                rx_state <= RX_BITS;
            end else if (rx_state == RX_DONE)
                rx_state <= RX_IDLE;
            else if (rx_state == RX_BITS)
                to_cnt <= to_cnt + 1'b1;
            if (scan_valid) begin
                dstate   <= d_next;
                skip_cnt <= d_next != D_SKIP ? 3'd0 : dstate == D_SKIP ? skip_cnt - 3'd1 : 3'd7;
                if (key_ev && hit) kbmatrix[idx] <= brk;
            end
        end
    end
endmodule

// File: tb/tb_ps2_kbmatrix.sv
// tb_ps2_kbmatrix: table-driven PS/2 frame vectors plus timeout, reset and Pause sequences
module tb_ps2_kbmatrix;
    localparam int F  = 4;
    localparam int T  = 300;
    localparam int HP = 10;
    localparam logic [63:0] ONES = '1;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [63:0] kbmatrix;
    logic [7:0]  scan_code;
    logic        scan_valid, rx_err;
    int n_chk = 0, n_fail = 0;
    int vld_cnt = 0, err_cnt = 0, both_cnt = 0;
    ps2_kbmatrix #(.FILTER_LEN(F), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .kbmatrix(kbmatrix), .scan_code(scan_code), .scan_valid(scan_valid), .rx_err(rx_err)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (scan_valid) vld_cnt++;
        if (rx_err) err_cnt++;
        if (scan_valid && rx_err) both_cnt++;
    end
    typedef struct {
        logic [7:0]  b;
        bit          bad;
        int          dv;
        int          de;
        logic [7:0]  code;
        logic [63:0] mat;
    } vec_t;
    vec_t vecs[15];
    function automatic logic [63:0] pm(input int a);
        logic [63:0] r = '1;
        r[a] = 1'b0;
        return r;
    endfunction
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic send_bit(input logic v);
        @(negedge clk);
        ps2_data = v;
        repeat (HP / 2) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HP) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HP / 2) @(negedge clk);
    endtask
    task automatic send_frame(input logic [7:0] b, input bit bad, input int nb);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nb; i++) send_bit(f[i]);
        repeat (20) @(negedge clk);
    endtask
    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
    endtask
    initial begin
        int v0, e0, n;
        logic [10:0] f;
        logic [7:0] pause_seq[8];
        vecs[0]  = '{8'h1C, 0, 1, 0, 8'h1C, pm(49)};
        vecs[1]  = '{8'hF0, 0, 1, 0, 8'hF0, pm(49)};
        vecs[2]  = '{8'h1C, 0, 1, 0, 8'h1C, ONES};
        vecs[3]  = '{8'hE0, 0, 1, 0, 8'hE0, ONES};
        vecs[4]  = '{8'h75, 0, 1, 0, 8'h75, pm(30)};
        vecs[5]  = '{8'hE0, 0, 1, 0, 8'hE0, pm(30)};
        vecs[6]  = '{8'hF0, 0, 1, 0, 8'hF0, pm(30)};
        vecs[7]  = '{8'h75, 0, 1, 0, 8'h75, ONES};
        vecs[8]  = '{8'h75, 0, 1, 0, 8'h75, ONES};
        vecs[9]  = '{8'h1C, 1, 0, 1, 8'h75, ONES};
        vecs[10] = '{8'h5A, 0, 1, 0, 8'h5A, pm(6)};
        vecs[11] = '{8'hE0, 0, 1, 0, 8'hE0, pm(6)};
        vecs[12] = '{8'h12, 0, 1, 0, 8'h12, pm(6)};
        vecs[13] = '{8'hF0, 0, 1, 0, 8'hF0, pm(6)};
        vecs[14] = '{8'h5A, 0, 1, 0, 8'h5A, ONES};
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        repeat (4) @(negedge clk);
        chk("reset_kbmatrix", kbmatrix, ONES);
        chk("reset_scan_code", 64'(scan_code), 64'h0);
        chk("reset_scan_valid", 64'(scan_valid), 64'h0);
        chk("reset_rx_err", 64'(rx_err), 64'h0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            v0 = vld_cnt;
            e0 = err_cnt;
            send_frame(vecs[i].b, vecs[i].bad, 11);
            chk($sformatf("vec%0d_valid", i), 64'(vld_cnt - v0), 64'(vecs[i].dv));
            chk($sformatf("vec%0d_err", i), 64'(err_cnt - e0), 64'(vecs[i].de));
            chk($sformatf("vec%0d_code", i), 64'(scan_code), 64'(vecs[i].code));
            chk($sformatf("vec%0d_matrix", i), kbmatrix, vecs[i].mat);
        end
        v0 = vld_cnt;
        e0 = err_cnt;
        f = {1'b1, ~^8'h12, 8'h12, 1'b0};
        for (int i = 0; i < 4; i++) send_bit(f[i]);
        @(negedge clk);
        ps2_data = f[4];
        repeat (HP / 2) @(negedge clk);
        ps2_clk = 1'b0;
        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            n++;
            #1;
            if (rx_err) break;
        end
        chk("timeout_latency", 64'(n), 64'(F + 2 + T));
        @(negedge clk);
        ps2_clk = 1'b1;
        repeat (30) @(negedge clk);
        chk("timeout_err", 64'(err_cnt - e0), 64'd1);
        chk("timeout_valid", 64'(vld_cnt - v0), 64'd0);
        chk("timeout_matrix", kbmatrix, ONES);
        send_byte(8'h12);
        chk("after_timeout_12", kbmatrix, pm(54));
        send_byte(8'h59);
        chk("shift_pair", kbmatrix, pm(54) & pm(63));
        send_byte(8'hE0);
        send_frame(8'h1C, 1'b0, 3);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midreset_matrix", kbmatrix, ONES);
        chk("midreset_code", 64'(scan_code), 64'h0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        send_byte(8'h75);
        chk("prefix_cleared_code", 64'(scan_code), 64'h75);
        chk("prefix_cleared_matrix", kbmatrix, ONES);
        v0 = vld_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 8; i++) send_byte(pause_seq[i]);
        chk("pause_valid", 64'(vld_cnt - v0), 64'd8);
        chk("pause_err", 64'(err_cnt - e0), 64'd0);
        chk("pause_matrix", kbmatrix, ONES);
        send_byte(8'h76);
        chk("esc_make", kbmatrix, pm(61));
        send_byte(8'hF0);
        send_byte(8'h76);
        chk("esc_break", kbmatrix, ONES);
        chk("valid_err_exclusive", 64'(both_cnt), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
